cam_fill_ctrl: RTL and testbench

Lookup/fill controller that drives the `cam` tag cache from the requester side. It accepts tag lookup requests and issues the CAM read. On a miss it fetches the line from backing memory over a request/ack handshake, chooses a victim slot and writes the line into the CAM through its active-low write port. It also provides a whole-CAM flush sequence. It is the only writer of the CAM and keeps a shadow valid vector so victim selection needs no extra CAM ports.

---
 rtl/cam_fill_ctrl_if.sv | 49 ++++
 rtl/cam_fill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cam_fill_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_fill_ctrl_if.sv
// Signal bundle around cam_fill_ctrl: requester handshake, flush control,
// CAM read/write ports and the backing-memory fetch handshake.
interface cam_fill_ctrl_if #(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1,
    parameter int TAG_SZ    = 8
);
    logic               req_valid;
    logic               req_ready;
    logic [TAG_SZ-1:0]  req_tag;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [BITS-1:0]    rsp_data;
    logic               rsp_hit;
    logic               flush;
    logic               flush_busy;
    logic               cam_read;
    logic [TAG_SZ-1:0]  cam_check_tag;
    logic [BITS-1:0]    cam_data;
    logic               cam_found;
    logic               cam_write_;
    logic [ADDR_LEFT:0] cam_w_addr;
    logic [BITS-1:0]    cam_wdata;
    logic [TAG_SZ-1:0]  cam_new_tag;
    logic               cam_new_valid;
    logic               mem_req;
    logic [TAG_SZ-1:0]  mem_tag;
    logic               mem_ack;
    logic [BITS-1:0]    mem_rdata;

    // Controller side: drives the CAM, the memory request and the response.
    modport master (
        input  req_valid, req_tag, rsp_ready, flush,
        input  cam_data, cam_found, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_hit, flush_busy,
        output cam_read, cam_check_tag, cam_write_, cam_w_addr,
        output cam_wdata, cam_new_tag, cam_new_valid, mem_req, mem_tag
    );

    // Environment side: requester, CAM and backing memory.
    modport slave (
        output req_valid, req_tag, rsp_ready, flush,
        output cam_data, cam_found, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_hit, flush_busy,
        input  cam_read, cam_check_tag, cam_write_, cam_w_addr,
        input  cam_wdata, cam_new_tag, cam_new_valid, mem_req, mem_tag
    );
endinterface

// File: rtl/cam_fill_ctrl.sv
// Lookup/fill controller for the tag CAM: lookup, miss fetch, victim fill and
// whole-CAM flush. A shadow valid vector mirrors the CAM for victim choice.
module cam_fill_ctrl #(
    parameter int WORDS     = 8,
    parameter int BITS      = 8,
    parameter int ADDR_LEFT = $clog2(WORDS) - 1,
    parameter int TAG_SZ    = 8
) (
    input  logic            clk,
    input  logic            rst,
    cam_fill_ctrl_if.master bus
);
    localparam int              AW        = ADDR_LEFT + 1;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MISS   = 3'd2,
        FILL   = 3'd3,
        RESP   = 3'd4,
        FLUSH  = 3'd5
    } state_t;

    state_t             state_q,      state_d;
    logic [TAG_SZ-1:0]  tag_q,        tag_d;
    logic [BITS-1:0]    data_q,       data_d;
    logic               hit_q,        hit_d;
    logic [WORDS-1:0]   shadow_v_q,   shadow_v_d;
    logic [AW-1:0]      rr_ptr_q,     rr_ptr_d;
    logic               flush_pend_q, flush_pend_d;
    logic [AW-1:0]      flush_cnt_q,  flush_cnt_d;

    logic [WORDS-1:0]   free_vec;
    logic [WORDS-1:0]   first_free;
    logic [WORDS-1:0]   fill_mask;
    logic               all_valid;
    logic [AW-1:0]      victim;
    logic [AW-1:0]      rr_ptr_inc;

    // Lowest clear shadow bit wins; round-robin only once every slot is valid.
    assign free_vec   = ~shadow_v_q;
    assign first_free = free_vec & (~free_vec + WORDS'(1));
    assign all_valid  = &shadow_v_q;
    assign rr_ptr_inc = (rr_ptr_q == LAST_ADDR) ? '0 : rr_ptr_q + 1'b1;

    always_comb begin
        victim = rr_ptr_q;
        for (int i = 0; i < WORDS; i++) begin
            if (first_free[i]) begin
                victim = AW'(i);
            end
        end
    end

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_fill_mask
        assign fill_mask[gi] = (victim == AW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            data_q       <= '0;
            hit_q        <= 1'b0;
            shadow_v_q   <= '0;
            rr_ptr_q     <= '0;
            flush_pend_q <= 1'b0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            hit_q        <= hit_d;
            shadow_v_q   <= shadow_v_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_pend_q <= flush_pend_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        data_d       = data_q;
        hit_d        = hit_q;
        shadow_v_d   = shadow_v_q;
        rr_ptr_d     = rr_ptr_q;
        flush_cnt_d  = flush_cnt_q;
        // Flush pulses merge into one pending flush, taken only from IDLE.
        flush_pend_d = flush_pend_q | bus.flush;
        case (state_q)
            IDLE: begin
                if (flush_pend_q) begin
                    flush_cnt_d = '0;
                    state_d     = FLUSH;
                end else if (bus.req_valid) begin
                    tag_d   = bus.req_tag;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cam_found) begin
                    data_d  = bus.cam_data;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (bus.mem_ack) begin
                    data_d  = bus.mem_rdata;
                    hit_d   = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                shadow_v_d = shadow_v_q | fill_mask;
                if (all_valid) begin
                    rr_ptr_d = rr_ptr_inc;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == LAST_ADDR) begin
                    shadow_v_d   = '0;
                    rr_ptr_d     = '0;
                    flush_pend_d = 1'b0;
                    flush_cnt_d  = '0;
                    state_d      = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While reset is asserted every output is forced to its idle value.
    always_comb begin
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.rsp_data      = '0;
        bus.rsp_hit       = 1'b0;
        bus.flush_busy    = 1'b0;
        bus.cam_read      = 1'b0;
        bus.cam_check_tag = '0;
        bus.cam_write_    = 1'b1;
        bus.cam_w_addr    = '0;
        bus.cam_wdata     = '0;
        bus.cam_new_tag   = '0;
        bus.cam_new_valid = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_tag       = '0;
        if (!rst) begin
            bus.cam_check_tag = tag_q;
            bus.mem_tag       = tag_q;
            bus.flush_busy    = flush_pend_q || (state_q == FLUSH);
            case (state_q)
                IDLE:   bus.req_ready = !flush_pend_q;
                LOOKUP: bus.cam_read  = 1'b1;
                MISS:   bus.mem_req   = 1'b1;
                FILL: begin
                    bus.cam_write_    = 1'b0;
                    bus.cam_w_addr    = victim;
                    bus.cam_wdata     = data_q;
                    bus.cam_new_tag   = tag_q;
                    bus.cam_new_valid = 1'b1;
                end
                RESP: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = data_q;
                    bus.rsp_hit   = hit_q;
                end
                FLUSH: begin
                    bus.cam_write_ = 1'b0;
                    bus.cam_w_addr = flush_cnt_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Randomized bench for cam_fill_ctrl: behavioural CAM and memory around the DUT,
// checked against a slot-array cache model of the expected fill behaviour.
module tb_cam_fill_ctrl;
    localparam int WORDS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_fill_ctrl_if #(.WORDS(WORDS), .BITS(8), .TAG_SZ(8)) bus ();

    cam_fill_ctrl #(.WORDS(WORDS), .BITS(8), .TAG_SZ(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural CAM: combinational match, write on the clock edge, reset with rst.
    logic [7:0] cam_tag_m [WORDS];
    logic [7:0] cam_dat_m [WORDS];
    logic       cam_v_m   [WORDS];

    always_comb begin
        bus.cam_found = 1'b0;
        bus.cam_data  = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (bus.cam_read && cam_v_m[i] && (cam_tag_m[i] == bus.cam_check_tag)) begin
                bus.cam_found = 1'b1;
                bus.cam_data  = cam_dat_m[i];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                cam_v_m[i]   <= 1'b0;
                cam_tag_m[i] <= '0;
                cam_dat_m[i] <= '0;
            end
        end else if (!bus.cam_write_) begin
            cam_v_m[bus.cam_w_addr]   <= bus.cam_new_valid;
            cam_tag_m[bus.cam_w_addr] <= bus.cam_new_tag;
            cam_dat_m[bus.cam_w_addr] <= bus.cam_wdata;
        end
    end

    // Reference cache: which tag lives in which slot, plus the round-robin pointer.
    bit         ref_v   [WORDS];
    logic [7:0] ref_tag [WORDS];
    logic [7:0] ref_dat [WORDS];
    int         ref_rr;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] mem_val(input logic [7:0] t);
        return t ^ 8'h99;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic ref_clear();
        for (int i = 0; i < WORDS; i++) begin
            ref_v[i] = 1'b0;
        end
        ref_rr = 0;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_cam_write_n", bus.cam_write_, 1);
        check("rst_cam_read", bus.cam_read, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_flush_busy", bus.flush_busy, 0);
        check("rst_addr_tags", {bus.cam_w_addr, bus.cam_check_tag, bus.mem_tag}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1);
        check("idle_cam_write_n", bus.cam_write_, 1);
        check("idle_cam_read", bus.cam_read, 0);
        check("idle_rsp_valid", bus.rsp_valid, 0);
        ref_clear();
        $display("reset done");
    endtask

    // One lookup from an IDLE cycle to the IDLE cycle after the response.
    task automatic do_req(input logic [7:0] tag, input int hold, input int ack_dly,
                          input bit flush_in_resp);
        bit         exp_hit;
        logic [7:0] exp_data;
        int         vic;
        int         dly;
        bit         acked, mem_seen, got_rsp;
        int         ack_cyc, first_mem, rsp_cyc, n_wr;
        exp_hit  = 1'b0;
        exp_data = '0;
        vic      = -1;
        dly      = ack_dly;
        acked    = 1'b0;
        mem_seen = 1'b0;
        got_rsp  = 1'b0;
        ack_cyc  = -1;
        first_mem = -1;
        rsp_cyc  = -1;
        n_wr     = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (ref_v[i] && ref_tag[i] == tag) begin
                exp_hit  = 1'b1;
                exp_data = ref_dat[i];
            end
        end
        if (!exp_hit) begin
            for (int i = WORDS - 1; i >= 0; i--) begin
                if (!ref_v[i]) vic = i;
            end
            if (vic < 0) begin
                vic    = ref_rr;
                ref_rr = (ref_rr + 1) % WORDS;
            end
            exp_data     = mem_val(tag);
            ref_v[vic]   = 1'b1;
            ref_tag[vic] = tag;
            ref_dat[vic] = exp_data;
        end

        check("req_ready_before", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_tag   = 8'($urandom);
        check("lookup_read_tag", {bus.cam_read, bus.cam_check_tag}, {1'b1, tag});

        for (int c = 2; c < 300 && !got_rsp; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!bus.cam_write_) begin
                n_wr++;
                check("fill_cycle", c, ack_cyc + 1);
                check("fill_addr", bus.cam_w_addr, vic);
                check("fill_tag", bus.cam_new_tag, tag);
                check("fill_data", bus.cam_wdata, exp_data);
                check("fill_valid", bus.cam_new_valid, 1);
            end
            if (bus.mem_req) begin
                if (!mem_seen) begin
                    first_mem = c;
                    check("mem_tag", bus.mem_tag, tag);
                end
                mem_seen = 1'b1;
                if (!acked) begin
                    if (dly == 0) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_val(tag);
                        acked         = 1'b1;
                        ack_cyc       = c;
                    end else begin
                        dly--;
                    end
                end
            end
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
                rsp_cyc = c;
            end
        end

        check("rsp_seen", got_rsp, 1);
        check("rsp_hit", bus.rsp_hit, exp_hit);
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_cycle", rsp_cyc, exp_hit ? 2 : ack_cyc + 2);
        check("mem_req_seen", mem_seen, !exp_hit);
        check("cam_write_count", n_wr, exp_hit ? 0 : 1);
        if (!exp_hit) check("mem_req_rise_cycle", first_mem, 2);
        $display("req tag=%02h %s data=%02h slot=%0d rsp_cycle=%0d hold=%0d flush=%0b",
                 tag, exp_hit ? "hit " : "miss", bus.rsp_data, vic, rsp_cyc, hold, flush_in_resp);

        for (int h = 0; h < hold; h++) begin
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_rsp_data", bus.rsp_data, exp_data);
            check("hold_rsp_hit", bus.rsp_hit, exp_hit);
            check("hold_req_ready", bus.req_ready, 0);
            bus.mem_ack   = (h == 0);
            bus.mem_rdata = ~exp_data;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        check("last_rsp_data", bus.rsp_data, exp_data);
        check("last_rsp_hit", bus.rsp_hit, exp_hit);
        bus.rsp_ready = 1'b1;
        bus.flush     = flush_in_resp;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.flush     = 1'b0;
        check("after_rsp_valid", bus.rsp_valid, 0);
        check("after_req_ready", bus.req_ready, !flush_in_resp);
        check("after_flush_busy", bus.flush_busy, flush_in_resp);
        check("after_cam_write_n", bus.cam_write_, 1);
    endtask

    task automatic check_flush();
        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            check("flush_write_n", bus.cam_write_, 0);
            check("flush_addr", bus.cam_w_addr, i);
            check("flush_new_valid", bus.cam_new_valid, 0);
            check("flush_tag_data", {bus.cam_new_tag, bus.cam_wdata}, 0);
            check("flush_busy", bus.flush_busy, 1);
            check("flush_req_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        check("flush_done_busy", bus.flush_busy, 0);
        check("flush_done_req_ready", bus.req_ready, 1);
        check("flush_done_write_n", bus.cam_write_, 1);
        ref_clear();
        $display("flush of %0d entries complete", WORDS);
    endtask

    task automatic rst_mid_miss(input logic [7:0] tag);
        check("mm_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mm_mem_req", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check("mm_rst_mem_req", bus.mem_req, 0);
        check("mm_rst_mem_tag", bus.mem_tag, 0);
        check("mm_rst_req_ready", bus.req_ready, 0);
        check("mm_rst_write_n", bus.cam_write_, 1);
        @(negedge clk);
        rst = 1'b0;
        ref_clear();
        #1;
        check("mm_idle_req_ready", bus.req_ready, 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h5E;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mm_late_write_n", bus.cam_write_, 1);
            check("mm_late_rsp_valid", bus.rsp_valid, 0);
            check("mm_late_mem_req", bus.mem_req, 0);
            @(negedge clk);
        end
        $display("reset during miss on tag %02h handled", tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        bit         fl;
        reset_dut();

        do_req(8'h3C, 0, 2, 1'b0);
        do_req(8'h3C, 0, 0, 1'b0);

        reset_dut();
        for (int i = 0; i < 10; i++) begin
            t = 8'h10 + 8'(i);
            do_req(t, $urandom_range(0, 1), $urandom_range(0, 3), 1'b0);
        end
        do_req(8'h10, 0, 1, 1'b0);
        do_req(8'h11, 0, 0, 1'b0);
        do_req(8'h12, 0, 2, 1'b0);
        do_req(8'h19, 5, 0, 1'b0);

        reset_dut();
        do_req(8'h40, 0, 1, 1'b0);
        do_req(8'h41, 1, 0, 1'b0);
        do_req(8'h42, 2, 3, 1'b1);
        check_flush();
        do_req(8'h40, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            t  = 8'h20 + 8'($urandom_range(0, 11));
            fl = ($urandom_range(0, 15) == 0);
            do_req(t, $urandom_range(0, 2), $urandom_range(0, 3), fl);
            if (fl) check_flush();
        end

        reset_dut();
        rst_mid_miss(8'h77);
        do_req(8'h3C, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
